// File: rtl/gpo_route_pkg.sv
// Shared types and default timing for the GPO line-matrix route sequencer.
package gpo_route_pkg;

  localparam int unsigned DEF_NUM_ENTRIES  = 16;
  localparam int unsigned DEF_SEL_W        = 4;
  localparam int unsigned DEF_RST_CYCLES   = 8;
  localparam int unsigned DEF_SETUP_CYCLES = 2;
  localparam int unsigned DEF_PULSE_CYCLES = 4;

  // Legacy state encodings, kept so existing scripts/waveform filters still match.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RESET  = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_CLK_HI = 3'd3;
  localparam logic [2:0] ST_CLK_LO = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    RESET  = ST_RESET,
    SETUP  = ST_SETUP,
    CLK_HI = ST_CLK_HI,
    CLK_LO = ST_CLK_LO,
    DONE   = ST_DONE
  } state_e;

  // One route: input select in the upper half, output select in the lower half.
  typedef struct packed {
    logic [DEF_SEL_W-1:0] in_sel;
    logic [DEF_SEL_W-1:0] out_sel;
  } route_entry_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gpo_route_timer.sv
// Loadable down-counter with zero flag; one instance times every sequencer phase.
module gpo_route_timer
  import gpo_route_pkg::*;
#(
  parameter int unsigned W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Load on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gpo_route_sequencer.sv
// Route-table loader for the accessory GPO line matrix: pulses matrix reset,
// then clocks each {in_sel, out_sel} entry in with fixed setup/pulse timing.
// Optional table readback port: define GPO_ROUTE_READBACK_EN.
module gpo_route_sequencer
  import gpo_route_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES  = DEF_NUM_ENTRIES,
  parameter int unsigned SEL_W        = DEF_SEL_W,
  parameter int unsigned RST_CYCLES   = DEF_RST_CYCLES,
  parameter int unsigned SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int unsigned PULSE_CYCLES = DEF_PULSE_CYCLES
) (
  input  logic                               sys_clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [$clog2(NUM_ENTRIES+1)-1:0]   num_entries,
  input  logic                               wr_en,
  input  logic [$clog2(NUM_ENTRIES)-1:0]     wr_addr,
  input  logic [2*SEL_W-1:0]                 wr_data,
  output logic                               line_clk,
  output logic                               line_rstn,
  output logic [SEL_W-1:0]                   line_in_sel,
  output logic [SEL_W-1:0]                   line_out_sel,
  output logic                               busy,
  output logic                               done,
  output logic                               wr_err
`ifdef GPO_ROUTE_READBACK_EN
  ,
  input  logic [$clog2(NUM_ENTRIES)-1:0]     rd_addr,
  output logic [2*SEL_W-1:0]                 rd_data
`endif
);

  localparam int unsigned AW   = $clog2(NUM_ENTRIES);
  localparam int unsigned CW   = $clog2(NUM_ENTRIES + 1);
  localparam int unsigned MAXC = max3(RST_CYCLES, SETUP_CYCLES, PULSE_CYCLES);
  localparam int unsigned TW   = $clog2(MAXC + 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        idx_q, idx_d;
  logic [2*SEL_W-1:0]   sel_q, sel_d;
  logic                 rstn_q, rstn_d;
  logic                 wr_err_q;
  logic [2*SEL_W-1:0]   tbl_q [NUM_ENTRIES];
  logic [2*SEL_W-1:0]   cur_entry;
  logic [CW-1:0]        clamped;
  logic                 tmr_load, tmr_zero;
  logic [TW-1:0]        tmr_val;

  assign clamped   = (num_entries > CW'(NUM_ENTRIES)) ? CW'(NUM_ENTRIES) : num_entries;
  assign cur_entry = tbl_q[idx_q[AW-1:0]];

  gpo_route_timer #(.W(TW)) u_timer (
    .clk_i      (sys_clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Phase sequencing; the timer is reloaded on every state entry.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rstn_d   = rstn_q;
    sel_d    = sel_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RESET;
          cnt_d    = clamped;
          rstn_d   = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = TW'(RST_CYCLES - 1);
        end
      end
      RESET: begin
        if (tmr_zero) begin
          if (cnt_q == '0) begin
            state_d = DONE;
          end else begin
            state_d  = SETUP;
            idx_d    = '0;
            rstn_d   = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = TW'(SETUP_CYCLES - 1);
          end
        end
      end
      SETUP: begin
        // Capture the entry so the selects hold through both clock phases.
        sel_d = cur_entry;
        if (tmr_zero) begin
          state_d  = CLK_HI;
          tmr_load = 1'b1;
          tmr_val  = TW'(PULSE_CYCLES - 1);
        end
      end
      CLK_HI: begin
        if (tmr_zero) begin
          state_d  = CLK_LO;
          tmr_load = 1'b1;
          tmr_val  = TW'(PULSE_CYCLES - 1);
        end
      end
      CLK_LO: begin
        if (tmr_zero) begin
          if ((idx_q + CW'(1)) < cnt_q) begin
            state_d  = SETUP;
            idx_d    = idx_q + CW'(1);
            tmr_load = 1'b1;
            tmr_val  = TW'(SETUP_CYCLES - 1);
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rstn_q  <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rstn_q  <= rstn_d;
      sel_q   <= sel_d;
    end
  end

  // Route table: writable only in IDLE, any other write is flagged.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) tbl_q[i] <= '0;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_en && (state_q != IDLE);
      if (wr_en && (state_q == IDLE) && (32'(wr_addr) < NUM_ENTRIES)) begin
        tbl_q[wr_addr] <= wr_data;
      end
    end
  end

`ifdef GPO_ROUTE_READBACK_EN
  logic [2*SEL_W-1:0] rd_data_q;

  // Registered table read, usable while a load is in progress.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= tbl_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;
`endif

  // During SETUP the selects come straight from the table; afterwards they hold.
  assign {line_in_sel, line_out_sel} = (state_q == SETUP) ? cur_entry : sel_q;
  assign line_clk  = (state_q == CLK_HI);
  assign line_rstn = rstn_q;
  assign busy      = (state_q == RESET) || (state_q == SETUP) ||
                     (state_q == CLK_HI) || (state_q == CLK_LO);
  assign done      = (state_q == DONE);
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_gpo_route_sequencer.sv
// Directed self-checking bench for gpo_route_sequencer (default parameters).
module tb_gpo_route_sequencer;
  import gpo_route_pkg::*;

  logic       sys_clk = 1'b0;
  logic       rst, start, wr_en;
  logic [4:0] num_entries;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       line_clk, line_rstn, busy, done, wr_err;
  logic [3:0] line_in_sel, line_out_sel;
`ifdef GPO_ROUTE_READBACK_EN
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Sequence observation results.
  int         m_busy, m_pulses, m_done, m_wmin, m_wmax, m_stab_err;
  logic [7:0] m_sel [32];

  always #5 sys_clk = ~sys_clk;

  gpo_route_sequencer dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .start        (start),
    .num_entries  (num_entries),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .line_clk     (line_clk),
    .line_rstn    (line_rstn),
    .line_in_sel  (line_in_sel),
    .line_out_sel (line_out_sel),
    .busy         (busy),
    .done         (done),
    .wr_err       (wr_err)
`ifdef GPO_ROUTE_READBACK_EN
    ,
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
`endif
  );

  task automatic write_entry(input logic [3:0] a, input logic [7:0] d);
    @(negedge sys_clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge sys_clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [4:0] n);
    @(negedge sys_clk);
    num_entries = n; start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  // Watch outputs each cycle until done (or budget runs out).
  task automatic monitor_seq(input int max_cyc);
    logic       pclk;
    logic [7:0] psel, rsel, cur;
    int         stab, hi;
    m_busy = 0; m_pulses = 0; m_done = 0; m_wmin = 999; m_wmax = 0; m_stab_err = 0;
    pclk = line_clk; psel = {line_in_sel, line_out_sel}; rsel = psel; stab = 1; hi = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge sys_clk);
      cur = {line_in_sel, line_out_sel};
      if (cur == psel) stab++; else stab = 1;
      if (busy) m_busy++;
      if (line_clk && !pclk) begin
        if (m_pulses < 32) m_sel[m_pulses] = cur;
        if (stab < 3) m_stab_err++;
        rsel = cur; hi = 1; m_pulses++;
      end else if (line_clk) begin
        hi++;
        if (cur != rsel) m_stab_err++;
      end else if (pclk) begin
        if (hi < m_wmin) m_wmin = hi;
        if (hi > m_wmax) m_wmax = hi;
        if (cur != rsel) m_stab_err++;
      end
      pclk = line_clk; psel = cur;
      if (done) begin
        m_done++;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    n_tests++; if (line_rstn !== 1'b0) begin n_fail++; $display("FAIL reset_rstn: got %b want 0", line_rstn); end
    n_tests++; if (line_clk !== 1'b0) begin n_fail++; $display("FAIL reset_clk: got %b want 0", line_clk); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if ({done, wr_err} !== 2'b00) begin n_fail++; $display("FAIL reset_done_err: got %b want 00", {done, wr_err}); end
    n_tests++; if ({line_in_sel, line_out_sel} !== 8'h00) begin n_fail++; $display("FAIL reset_sel: got %h want 00", {line_in_sel, line_out_sel}); end
`ifdef GPO_ROUTE_READBACK_EN
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      @(negedge sys_clk);
      n_tests++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_table[%0d]: got %h want 00", i, rd_data); end
    end
`endif
    @(negedge sys_clk);
    rst = 1'b0;
  endtask

  task automatic test_three_entry();
    route_entry_t e0, e1, e2;
    e0 = '{in_sel: 4'd1, out_sel: 4'd5};
    e1 = '{in_sel: 4'd3, out_sel: 4'd9};
    e2 = '{in_sel: 4'd7, out_sel: 4'd2};
    write_entry(4'd0, e0);
    write_entry(4'd1, e1);
    // Last write lands in the same cycle as start; the load must see it.
    @(negedge sys_clk);
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = e2; num_entries = 5'd3; start = 1'b1;
    @(posedge sys_clk); #1;
    wr_en = 1'b0; start = 1'b0;
    monitor_seq(200);
    n_tests++; if (m_busy !== 38) begin n_fail++; $display("FAIL three_busy_cycles: got %0d want 38", m_busy); end
    n_tests++; if (m_pulses !== 3) begin n_fail++; $display("FAIL three_pulses: got %0d want 3", m_pulses); end
    n_tests++; if (m_wmin !== 4 || m_wmax !== 4) begin n_fail++; $display("FAIL three_width: got %0d..%0d want 4", m_wmin, m_wmax); end
    n_tests++; if (m_sel[0] !== 8'h15) begin n_fail++; $display("FAIL three_sel0: got %h want 15", m_sel[0]); end
    n_tests++; if (m_sel[1] !== 8'h39) begin n_fail++; $display("FAIL three_sel1: got %h want 39", m_sel[1]); end
    n_tests++; if (m_sel[2] !== 8'h72) begin n_fail++; $display("FAIL three_sel2: got %h want 72", m_sel[2]); end
    n_tests++; if (m_stab_err !== 0) begin n_fail++; $display("FAIL three_sel_stable: got %0d glitches want 0", m_stab_err); end
    n_tests++; if (m_done !== 1) begin n_fail++; $display("FAIL three_done: got %0d want 1", m_done); end
    @(negedge sys_clk);
    n_tests++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL three_idle: got done,busy=%b want 00", {done, busy}); end
    n_tests++; if (line_rstn !== 1'b1) begin n_fail++; $display("FAIL three_rstn_hold: got %b want 1", line_rstn); end
    n_tests++; if ({line_in_sel, line_out_sel} !== 8'h72) begin n_fail++; $display("FAIL three_sel_hold: got %h want 72", {line_in_sel, line_out_sel}); end
  endtask

  task automatic test_zero_entries();
    pulse_start(5'd0);
    monitor_seq(100);
    n_tests++; if (m_busy !== 8) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d want 8", m_busy); end
    n_tests++; if (m_pulses !== 0) begin n_fail++; $display("FAIL zero_pulses: got %0d want 0", m_pulses); end
    n_tests++; if (m_done !== 1) begin n_fail++; $display("FAIL zero_done: got %0d want 1", m_done); end
  endtask

  task automatic test_write_busy();
    bit seen;
    seen = 1'b0;
    pulse_start(5'd1);
    for (int c = 0; c < 40; c++) begin
      @(negedge sys_clk);
      if (line_clk) begin seen = 1'b1; break; end
    end
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL wbusy_reach_clkhi: got %b want 1", seen); end
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hAA;
    @(posedge sys_clk); #1;
    wr_en = 1'b0;
    @(negedge sys_clk);
    n_tests++; if (wr_err !== 1'b1) begin n_fail++; $display("FAIL wbusy_err_pulse: got %b want 1", wr_err); end
    @(negedge sys_clk);
    n_tests++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL wbusy_err_clear: got %b want 0", wr_err); end
    monitor_seq(100);
    n_tests++; if (m_done !== 1) begin n_fail++; $display("FAIL wbusy_done: got %0d want 1", m_done); end
`ifdef GPO_ROUTE_READBACK_EN
    rd_addr = 4'd0;
    @(negedge sys_clk);
    n_tests++; if (rd_data !== 8'h15) begin n_fail++; $display("FAIL wbusy_readback: got %h want 15", rd_data); end
`endif
    pulse_start(5'd1);
    monitor_seq(100);
    n_tests++; if (m_sel[0] !== 8'h15) begin n_fail++; $display("FAIL wbusy_entry_kept: got %h want 15", m_sel[0]); end
  endtask

  task automatic test_clamp_restart();
    pulse_start(5'd17);
    fork
      monitor_seq(400);
      begin
        repeat (30) @(negedge sys_clk);
        num_entries = 5'd2; start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
      end
    join
    n_tests++; if (m_pulses !== 16) begin n_fail++; $display("FAIL clamp_pulses: got %0d want 16", m_pulses); end
    n_tests++; if (m_busy !== 168) begin n_fail++; $display("FAIL clamp_busy_cycles: got %0d want 168", m_busy); end
    n_tests++; if (m_done !== 1) begin n_fail++; $display("FAIL clamp_done: got %0d want 1", m_done); end
    repeat (5) @(negedge sys_clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_not_queued: got busy=%b want 0", busy); end
  endtask

  task automatic test_mid_reset();
    int dcount;
    pulse_start(5'd3);
    repeat (19) @(negedge sys_clk);
    n_tests++; if ({line_rstn, line_clk, line_in_sel, line_out_sel} !== {2'b10, 8'h39}) begin
      n_fail++; $display("FAIL midrst_in_setup2: got %b_%h want 10_39", {line_rstn, line_clk}, {line_in_sel, line_out_sel});
    end
    rst = 1'b1;
    #1;
    n_tests++; if ({line_rstn, line_clk, busy, done} !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_outputs: got rstn,clk,busy,done=%b want 0000", {line_rstn, line_clk, busy, done});
    end
    n_tests++; if ({line_in_sel, line_out_sel} !== 8'h00) begin n_fail++; $display("FAIL midrst_sel: got %h want 00", {line_in_sel, line_out_sel}); end
    @(negedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b0;
    dcount = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge sys_clk);
      if (done || busy) dcount++;
    end
    n_tests++; if (dcount !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d active cycles want 0", dcount); end
    // Table was cleared by reset, so a one-entry load drives zeros.
    pulse_start(5'd1);
    monitor_seq(100);
    n_tests++; if (m_sel[0] !== 8'h00 || m_done !== 1) begin
      n_fail++; $display("FAIL midrst_table_cleared: got sel=%h done=%0d want 00/1", m_sel[0], m_done);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wr_en = 1'b0; num_entries = '0; wr_addr = '0; wr_data = '0;
`ifdef GPO_ROUTE_READBACK_EN
    rd_addr = '0;
`endif
    test_reset();
    test_three_entry();
    test_zero_entries();
    test_write_busy();
    test_clamp_restart();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
